// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, default PC step and
// the instruction alignment check.
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_TRAP = 2'd2
   } fetch_state_e;

   localparam int unsigned DEFAULT_PC_STEP = 4;
   localparam logic [1:0]  ALIGN_MASK      = 2'b11;

   function automatic logic is_aligned(input logic [1:0] low_bits);
      return (low_bits & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// 64-bit program counter: synchronous reset, load (redirect) over increment,
// otherwise hold. Increment wraps modulo 2^64.
module instruction_fetch_program_counter
   import instruction_fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_en,
   input  logic [63:0] load_pc,
   input  logic        inc_en,
   output logic [63:0] pc
);

   logic [63:0] pc_q;
   logic [63:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_pc;
      end else if (inc_en) begin
         pc_d = pc_q + 64'(PC_STEP);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives PC onto the instruction memory, registers the returned
// word with its PC and hands it to decode over valid/ready.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        FETCH_EN,
   output logic [63:0] IMEM_ADDR,
   input  logic [31:0] IMEM_DATA,
   input  logic        BRANCH_TAKEN,
   input  logic [63:0] BRANCH_TARGET,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_INSTR,
   output logic [63:0] OUT_PC,
   output logic        MISALIGNED
);

   fetch_state_e state_q, state_d;
   logic         out_valid_q, out_valid_d;
   logic [31:0]  out_instr_q, out_instr_d;
   logic [63:0]  out_pc_q, out_pc_d;
   logic         misaligned_q, misaligned_d;
   logic         pc_load;
   logic         pc_inc;
   logic [63:0]  pc;
   logic         slot_free;

   instruction_fetch_program_counter #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc (
      .clk     (CLK),
      .rst     (RST),
      .load_en (pc_load),
      .load_pc (BRANCH_TARGET),
      .inc_en  (pc_inc),
      .pc      (pc)
   );

   assign slot_free = !out_valid_q || OUT_READY;

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_pc_d     = out_pc_q;
      misaligned_d = misaligned_q;
      pc_load      = 1'b0;
      pc_inc       = 1'b0;

      case (state_q)
         ST_TRAP: begin
            out_valid_d  = 1'b0;
            misaligned_d = 1'b1;
         end
         ST_IDLE, ST_RUN: begin
            if (BRANCH_TAKEN) begin
               // Redirect flushes the slot even when decode is stalling.
               out_valid_d = 1'b0;
               if (is_aligned(BRANCH_TARGET[1:0])) begin
                  pc_load = 1'b1;
                  state_d = FETCH_EN ? ST_RUN : ST_IDLE;
               end else begin
                  misaligned_d = 1'b1;
                  state_d      = ST_TRAP;
               end
            end else if (state_q == ST_IDLE) begin
               out_valid_d = 1'b0;
               if (FETCH_EN) begin
                  state_d = ST_RUN;
               end
            end else if (slot_free) begin
               if (FETCH_EN) begin
                  out_instr_d = IMEM_DATA;
                  out_pc_d    = pc;
                  out_valid_d = 1'b1;
                  pc_inc      = 1'b1;
               end else begin
                  out_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         out_valid_q  <= 1'b0;
         out_instr_q  <= 32'h0;
         out_pc_q     <= 64'h0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_pc_q     <= out_pc_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign IMEM_ADDR  = pc;
   assign OUT_VALID  = out_valid_q;
   assign OUT_INSTR  = out_instr_q;
   assign OUT_PC     = out_pc_q;
   assign MISALIGNED = misaligned_q;

endmodule
